// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake and serial line bundle for uart_tx
//
// Signals:
//   iData    [7:0]  byte to send, sampled on the accepting edge
//   iTxSend         send request, honoured only while the transmitter is idle
//   oTx             serial line, idles high
//   oBusy           high from accept until the frame completes
//   oTxDone         one-cycle pulse at frame completion
// Modports: master = sender stage, slave = transmitter.
interface uart_tx_if;
    logic [7:0] iData;
    logic       iTxSend;
    logic       oTx;
    logic       oBusy;
    logic       oTxDone;

    modport master (output iData, output iTxSend,
                    input  oTx,   input  oBusy, input oTxDone);
    modport slave  (input  iData, input  iTxSend,
                    output oTx,   output oBusy, output oTxDone);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 (or 8E1) asynchronous serial transmitter
//
// Parameters: CLK_HZ (system clock, Hz), BAUD (line rate); one bit lasts
//             CLK_HZ/BAUD clocks, truncated, and must be at least 2.
// Ports:
//   iClock          system clock, rising edge
//   iReset_n        asynchronous active-low reset
//   bus (slave)     iData/iTxSend in, oTx/oBusy/oTxDone out (all outputs registered)
// Build option: define UART_TX_PARITY_EN for an even-parity bit between
//               the data and stop bits (8E1); undefined gives 8N1.
module uart_tx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       iClock,
    input  logic       iReset_n,
    uart_tx_if.slave   bus
);
    localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [15:0] LAST_CNT     = 16'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_HZ/BAUD must be at least 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t      r_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    logic w_bit_end;
    assign w_bit_end = (r_clk_cnt == LAST_CNT);

    // Every transition drives the level of the *next* bit so that oTx
    // changes exactly on the bit boundary edge.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (bus.iTxSend) begin
                        r_shift <= bus.iData;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^bus.iData;
`endif
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        // Returning to IDLE here lets a send in the done
                        // cycle start the next frame with no idle gap.
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oTx     = r_tx;
    assign bus.oBusy   = r_busy;
    assign bus.oTxDone = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (CLK_HZ=16, BAUD=4)
module tb_uart_tx;
    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11 * N;
`else
    localparam int FL = 10 * N;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    uart_tx_if bus ();

    uart_tx #(.CLK_HZ(16), .BAUD(4)) dut (
        .iClock   (clk),
        .iReset_n (rst_n),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level t cycles after the accept edge.
    function automatic logic exp_bit(input logic [7:0] d, input int t);
        int slot;
        slot = t / N;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot - 1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Sends d, checks every cycle of the frame and the done cycle. Leaves
    // the bench in the done cycle so a following call is back-to-back.
    // glitch_t: cycle at which a stray send with 0xFF is pulsed (-1 none).
    // hold: keep iTxSend high for the whole frame.
    task automatic drive_frame(input logic [7:0] d, input int glitch_t,
                               input bit hold, input string tag);
        logic e;
        bus.iData   = d;
        bus.iTxSend = 1'b1;
        tick();
        for (int t = 0; t < FL; t++) begin
            e = exp_bit(d, t);
            n_checks++;
            if (bus.oTx !== e)
                $display("FAIL %s tx t=%0d got=%b want=%b", tag, t, bus.oTx, e);
            else n_pass++;
            n_checks++;
            if (bus.oBusy !== 1'b1)
                $display("FAIL %s busy t=%0d got=%b want=1", tag, t, bus.oBusy);
            else n_pass++;
            n_checks++;
            if (bus.oTxDone !== 1'b0)
                $display("FAIL %s done_early t=%0d got=%b want=0", tag, t, bus.oTxDone);
            else n_pass++;
            bus.iTxSend = hold || (t == glitch_t);
            bus.iData   = (t == glitch_t) ? 8'hFF : 8'($urandom);
            tick();
        end
        n_checks++;
        if ({bus.oTxDone, bus.oBusy, bus.oTx} !== 3'b101)
            $display("FAIL %s done_cycle got done/busy/tx=%b%b%b want=101",
                     tag, bus.oTxDone, bus.oBusy, bus.oTx);
        else n_pass++;
        bus.iTxSend = 1'b0;
    endtask

    task automatic test_reset();
        bus.iTxSend = 1'b0;
        bus.iData   = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.oTx, bus.oBusy, bus.oTxDone} !== 3'b100)
            $display("FAIL reset_async got tx/busy/done=%b%b%b want=100",
                     bus.oTx, bus.oBusy, bus.oTxDone);
        else n_pass++;
        bus.iTxSend = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.iData = 8'($urandom);
            tick();
            n_checks++;
            if ({bus.oTx, bus.oBusy, bus.oTxDone} !== 3'b100)
                $display("FAIL reset_hold c=%0d got tx/busy/done=%b%b%b want=100",
                         i, bus.oTx, bus.oBusy, bus.oTxDone);
            else n_pass++;
        end
        bus.iTxSend = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.oTx, bus.oBusy, bus.oTxDone} !== 3'b100)
            $display("FAIL reset_release got tx/busy/done=%b%b%b want=100",
                     bus.oTx, bus.oBusy, bus.oTxDone);
        else n_pass++;
    endtask

    task automatic test_single();
        drive_frame(8'h55, -1, 1'b0, "single55");
        tick();
        n_checks++;
        if ({bus.oTxDone, bus.oTx} !== 2'b01)
            $display("FAIL single_pulse got done/tx=%b%b want=01", bus.oTxDone, bus.oTx);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        drive_frame(8'hA3, 12, 1'b0, "busyA3");
        tick();
        n_checks++;
        if ({bus.oTxDone, bus.oBusy} !== 2'b00)
            $display("FAIL busy_no_requeue got done/busy=%b%b want=00",
                     bus.oTxDone, bus.oBusy);
        else n_pass++;
    endtask

    task automatic test_random();
        int gap;
        for (int i = 0; i < 6; i++) begin
            drive_frame(8'($urandom), int'($urandom_range(0, FL - 1)), 1'b0, "random");
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                n_checks++;
                if ({bus.oTxDone, bus.oTx} !== 2'b01)
                    $display("FAIL random_gap got done/tx=%b%b want=01", bus.oTxDone, bus.oTx);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_frame(8'($urandom), -1, 1'b0, "b2b_first");
        drive_frame(8'h01, -1, 1'b0, "b2b_second");
        drive_frame(8'($urandom), -1, 1'b1, "hold_a");
        drive_frame(8'($urandom), -1, 1'b1, "hold_b");
        drive_frame(8'($urandom), -1, 1'b0, "hold_c");
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] d;
        d = 8'h5A;
        bus.iData   = d;
        bus.iTxSend = 1'b1;
        tick();
        bus.iTxSend = 1'b0;
        for (int t = 0; t < 18; t++) begin
            n_checks++;
            if (bus.oTx !== exp_bit(d, t))
                $display("FAIL abort_pre tx t=%0d got=%b want=%b", t, bus.oTx, exp_bit(d, t));
            else n_pass++;
            tick();
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.oTx, bus.oBusy, bus.oTxDone} !== 3'b100)
            $display("FAIL abort_async got tx/busy/done=%b%b%b want=100",
                     bus.oTx, bus.oBusy, bus.oTxDone);
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < FL + 4; i++) begin
            tick();
            n_checks++;
            if ({bus.oTx, bus.oBusy, bus.oTxDone} !== 3'b100)
                $display("FAIL abort_after c=%0d got tx/busy/done=%b%b%b want=100",
                         i, bus.oTx, bus.oBusy, bus.oTxDone);
            else n_pass++;
        end
        drive_frame(8'h80, -1, 1'b0, "abort_80");
        tick();
    endtask

    task automatic test_parity_byte();
        drive_frame(8'h07, -1, 1'b0, "byte07");
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single();
        test_busy_ignore();
        test_random();
        test_back_to_back();
        test_abort();
        test_parity_byte();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Asynchronous serial transmitter for the RS-232 test path: accepts one byte per send pulse from the memory-dump sender stage and shifts it out as an 8N1 frame on the TX line. It sits directly downstream of the sender FSM. The sender drives `iData` and a one-cycle `iTxSend` pulse, then waits for this block's one-cycle `oTxDone` before moving to the next address.

## Interface
- `CLK_HZ`, default 50000000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT` (localparam) = `CLK_HZ / BAUD`, integer division, truncated. Must be ≥ 2; otherwise elaboration fails via a generate-time `$error`.

Ports:
- `iClock` in 1: system clock, rising edge.
- `iReset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `iData` in 8: byte to send. Sampled only on the accepting edge.
- `iTxSend` in 1: send request. Acted on only in IDLE.
- `oTx` out 1: serial line. Idles high.
- `oBusy` out 1: high from the accept edge until the frame completes.
- `oTxDone` out 1: one-cycle pulse at frame completion.

## Operation
- **States:** IDLE, START, DATA, (PARITY), STOP. 3-bit state register. Unused encodings go to IDLE with `oTx`=1.
- **Bit counter:** 16-bit; counts 0..`CLKS_PER_BIT`-1 per bit. Separate 3-bit data index.
- **IDLE**
  - `oTx`=1.
  - `iTxSend`=1 at an edge: latch `iData` into the shift register, `oTx`<=0, `oBusy`<=1, go to START.
- **START:** hold `oTx`=0 for `CLKS_PER_BIT` cycles. Then `oTx`<=shift[0] and go to DATA.
- **DATA**
  - Each bit held `CLKS_PER_BIT` cycles, LSB first.
  - After bit 7: go to STOP with `oTx`<=1, or to PARITY when parity is enabled.
- **PARITY (only with macro):** one bit time carrying the even-parity bit (XOR of the latched byte). Then STOP, `oTx`<=1.
- **STOP:** `oTx`=1 for `CLKS_PER_BIT` cycles. On the final edge: state<=IDLE, `oBusy`<=0, `oTxDone`<=1 for exactly one cycle.
- **`iTxSend` while busy:** ignored. No queueing, no effect on the frame in progress.
- **Data stability:** `iData` changes after the accept edge do not affect the frame.
- **Send in the `oTxDone` cycle:** the state is already IDLE, so `iTxSend` is accepted on that cycle's edge. Back-to-back frames have no extra idle time.
- **`iTxSend` held high continuously:** frames repeat back-to-back. Each completed frame produces one `oTxDone` pulse.
- **Reset**
  - Reset values: `oTx`=1, `oBusy`=0, `oTxDone`=0, state=IDLE, counters=0.
  - Mid-frame reset aborts the frame; the line returns high asynchronously.
  - No `oTxDone` is issued for an aborted frame.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Accept edge E0:
  - `oTx` falls after E0.
  - Start bit occupies cycles E0..E0+N-1, where N = `CLKS_PER_BIT`.
  - Data bit k is driven from E0+(k+1)·N.
  - Stop bit starts at E0+9N.
  - `oTxDone` high in the cycle after edge E0+10N. With parity, these points shift by +N (stop at E0+10N, done at E0+11N).
- Frame length: 10N cycles; 11N with parity.
- Baud error from truncation is accepted as-is. No fractional accumulation.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: frame is 8E1. The PARITY state is compiled in; the parity bit is the even parity of the latched byte.
  - Undefined: frame is 8N1. The PARITY state and its logic are absent, and the state encoding is unchanged otherwise.

## Test plan
All scenarios use CLK_HZ=16, BAUD=4 (N=4).
- **Reset idle:** assert `iReset_n`=0 mid-cycle -> `oTx`=1, `oBusy`=0, `oTxDone`=0 immediately. Hold 20 cycles with `iTxSend`=1 -> no change.
- **Single byte:** send 0x55 -> `oTx` sequence, each level 4 cycles: 0, 1,0,1,0,1,0,1,0, 1. Exactly one `oTxDone` pulse 40 cycles after accept; `oBusy` high for 40 cycles.
- **Busy ignore:** send 0xA3, pulse `iTxSend` with `iData`=0xFF at cycle 12 -> line carries 0xA3 only, a single `oTxDone`.
- **Back-to-back:** assert `iTxSend` with 0x01 on the `oTxDone` cycle -> second start bit begins the next cycle, with no idle gap.
- **Abort:** pull `iReset_n` low at cycle 18 of a frame -> `oTx`=1 at once, no `oTxDone`. After release, a send of 0x80 frames correctly.
- **Parity build:** with `UART_TX_PARITY_EN`, send 0x07 -> parity bit 1 at cycles 36..39, stop bit at 40..43, `oTxDone` after 44 cycles.
